pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RISC-V core (fetch / decoder / id_exe / exe / reg_file).
- Detects read-after-write hazards between the instruction in decode and the instruction in execute, and detects taken jumps from execute.
- Drives the pipeline `hold` (freeze fetch and decoder), `bubble` (clear the id_exe register) and `flush` (clear fetch and decode) controls.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- STALL_CYCLES, 2: total cycles `hold` is asserted per detected hazard, counting the detection cycle; legal range 1..15.
- FLUSH_CYCLES, 2: total cycles `flush` is asserted per taken jump, counting the detection cycle; legal range 1..15.
- CNT_W, 16: width of the event counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs1  in  5  rs1 index of the instruction in decode.
- id_rs2  in  5  rs2 index of the instruction in decode.
- id_rs1_used  in  1  decode instruction reads rs1.
- id_rs2_used  in  1  decode instruction reads rs2.
- ex_rd  in  5  destination register of the instruction in execute.
- ex_wr_en  in  1  execute instruction will write ex_rd.
- jmp_en  in  1  execute resolved a taken jump or branch this cycle.
- hold  out  1  freeze the fetch PC and the decoder output register.
- bubble  out  1  load a NOP into id_exe next edge.
- flush  out  1  clear the fetch and decoder registers next edge.
- state  out  2  current FSM state: 0 = RUN, 1 = STALL, 2 = FLUSH.
- stall_cnt  out  CNT_W  number of hazard events, saturating at all-ones.
- flush_cnt  out  CNT_W  number of jump events, saturating at all-ones.

Behaviour:
- Reset (async, rst=1):
  - State RUN, internal down-counter 0.
  - stall_cnt = 0 and flush_cnt = 0.
  - Outputs hold, bubble and flush are 0 while reset is asserted.
- Hazard term (combinational):
  - haz = ex_wr_en && ex_rd != 0 && ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd)).
  - x0 never causes a hazard.
- Outputs are combinational from the current state and current inputs; there is no added latency.
- Priority: jmp_en > haz > nothing, in every state.
- RUN:
  - If jmp_en: flush = 1 this cycle and flush_cnt increments. Next state is FLUSH with counter loaded to FLUSH_CYCLES-1; if FLUSH_CYCLES = 1, stay in RUN.
  - Else if haz: hold = 1 and bubble = 1 this cycle, and stall_cnt increments. Next state is STALL with counter loaded to STALL_CYCLES-1; if STALL_CYCLES = 1, stay in RUN.
  - Else: all controls are 0.
- STALL:
  - hold = 1 and bubble = 1 every cycle; haz is not re-evaluated and stall_cnt does not increment.
  - Counter decrements each edge. When the counter is 1 at the edge, next state is RUN.
  - Net effect: STALL lasts STALL_CYCLES-1 cycles.
  - jmp_en in STALL: hold = 0, bubble = 0, flush = 1 and flush_cnt increments. Transition follows the RUN jmp_en rule. The stall is abandoned because the stalled instruction is squashed.
- FLUSH:
  - flush = 1 every cycle; hold = 0 and bubble = 0. haz is ignored because decode contents are being discarded.
  - Counter decrements each edge; when it is 1 at the edge, next state is RUN.
  - jmp_en in FLUSH restarts the flush: counter reloads to FLUSH_CYCLES-1 (or returns to RUN if that value is 0), and flush_cnt increments.
- Counters:
  - Increment by 1 per event edge and saturate at 2^CNT_W-1; they never wrap.
  - Only rst clears them.
- Simultaneous jmp_en and haz: treated as a jump only. flush_cnt increments; stall_cnt does not.
- Reset mid-STALL or mid-FLUSH: immediate return to RUN and all outputs 0. After reset deasserts, the first edge evaluates inputs as in RUN.
- state = 3 is unreachable; if reached, next state is RUN and the counter is cleared.

Test Plan:
1. Reset, then ex_wr_en=1, ex_rd=5, id_rs1=5, id_rs1_used=1 for one cycle -> hold=1 and bubble=1 for exactly 2 cycles, state sequence RUN, STALL, RUN, stall_cnt=1.
2. ex_rd=0, ex_wr_en=1, id_rs1=0, id_rs1_used=1 -> hold stays 0 and stall_cnt stays 0. Also id_rs2=7 with id_rs2_used=0 and ex_rd=7 -> no hazard.
3. jmp_en=1 for one cycle in RUN -> flush=1 for 2 cycles and hold=0 throughout, flush_cnt=1. jmp_en and haz together -> same result, with stall_cnt unchanged.
4. Hazard detected, then jmp_en=1 in the STALL cycle -> hold drops in that cycle, flush=1 for 2 cycles starting there, stall_cnt=1, flush_cnt=1.
5. Reparameterise STALL_CYCLES=4 and FLUSH_CYCLES=1 -> hold is high for 4 cycles per hazard. jmp_en yields flush=1 for 1 cycle and the FSM stays in RUN.
6. Assert rst asynchronously mid-FLUSH (between edges) -> flush drops immediately, state=0, both counters 0. Then force 2^16+3 hazards -> stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central sequencer for the 5-stage pipeline (fetch / decoder / id_exe /
// exe / reg_file). It watches for read-after-write hazards between the
// instruction in decode and the one in execute, and for taken jumps that
// execute resolves. From these it drives the freeze (hold), NOP insert
// (bubble) and squash (flush) controls. It also keeps two saturating debug
// counters of stall and flush events.
//
// Ports:
//   clk          pipeline clock, rising-edge active
//   rst          asynchronous active-high reset
//   id_rs1       rs1 index of the decode instruction
//   id_rs2       rs2 index of the decode instruction
//   id_rs1_used  decode instruction reads rs1
//   id_rs2_used  decode instruction reads rs2
//   ex_rd        destination register of the execute instruction
//   ex_wr_en     execute instruction writes ex_rd
//   jmp_en       execute resolved a taken jump/branch this cycle
//   hold         freeze fetch PC and decoder output register
//   bubble       load a NOP into id_exe on the next edge
//   flush        clear fetch and decoder registers on the next edge
//   state        current FSM state (0 RUN, 1 STALL, 2 FLUSH)
//   stall_cnt    hazard event count, saturating
//   flush_cnt    jump event count, saturating
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int STALL_CYCLES = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_wr_en,
  input  logic             jmp_en,
  output logic             hold,
  output logic             bubble,
  output logic             flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // The detection cycle is itself the first cycle of hold/flush, so the
  // down-counter only has to cover the remaining cycles.
  localparam logic [3:0] STALL_LOAD = 4'(STALL_CYCLES - 1);
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     cur_state;
  state_t     nxt_state;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       haz;
  logic       hold_c;
  logic       bubble_c;
  logic       flush_c;
  logic       stall_ev;
  logic       flush_ev;

  // Register x0 is hard-wired to zero, so a write to it never creates a
  // dependency.
  assign haz = ex_wr_en && (ex_rd != 5'd0) &&
               ((id_rs1_used && (id_rs1 == ex_rd)) ||
                (id_rs2_used && (id_rs2 == ex_rd)));

  // Next-state and control decode. A taken jump wins in every state: it
  // squashes whatever decode holds, which also makes any pending stall moot.
  always_comb begin
    nxt_state = cur_state;
    cnt_nxt   = cnt;
    hold_c    = 1'b0;
    bubble_c  = 1'b0;
    flush_c   = 1'b0;
    stall_ev  = 1'b0;
    flush_ev  = 1'b0;

    if (cur_state != RUN && cur_state != STALL && cur_state != FLUSH) begin
      nxt_state = RUN;
      cnt_nxt   = 4'd0;
    end else if (jmp_en) begin
      flush_c  = 1'b1;
      flush_ev = 1'b1;
      if (FLUSH_LOAD != 4'd0) begin
        nxt_state = FLUSH;
        cnt_nxt   = FLUSH_LOAD;
      end else begin
        nxt_state = RUN;
        cnt_nxt   = 4'd0;
      end
    end else begin
      case (cur_state)
        RUN: begin
          if (haz) begin
            hold_c   = 1'b1;
            bubble_c = 1'b1;
            stall_ev = 1'b1;
            if (STALL_LOAD != 4'd0) begin
              nxt_state = STALL;
              cnt_nxt   = STALL_LOAD;
            end
          end
        end
        STALL: begin
          hold_c   = 1'b1;
          bubble_c = 1'b1;
          if (cnt <= 4'd1) begin
            nxt_state = RUN;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
        FLUSH: begin
          flush_c = 1'b1;
          if (cnt <= 4'd1) begin
            nxt_state = RUN;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
        default: begin
          nxt_state = RUN;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  // Controls are combinational, so they are masked during reset to keep a
  // stray jmp_en or hazard from reaching the pipeline while it is cleared.
  assign hold   = hold_c   & ~rst;
  assign bubble = bubble_c & ~rst;
  assign flush  = flush_c  & ~rst;
  assign state  = cur_state;

  // FSM state and down-counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= RUN;
      cnt       <= 4'd0;
    end else begin
      cur_state <= nxt_state;
      cnt       <= cnt_nxt;
    end
  end

  // Debug event counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush_ev && flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl. Three instances share the same
// stimulus: the default configuration (driven from a vector table through a
// scoreboard queue), a STALL_CYCLES=4 / FLUSH_CYCLES=1 variant, and a narrow
// counter variant used to reach saturation quickly.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] ex_rd;
  logic       ex_wr_en;
  logic       jmp_en;

  logic        hold_m, bubble_m, flush_m;
  logic [1:0]  state_m;
  logic [15:0] stall_cnt_m, flush_cnt_m;

  logic        hold_5, bubble_5, flush_5;
  logic [1:0]  state_5;
  logic [15:0] stall_cnt_5, flush_cnt_5;

  logic        hold_s, bubble_s, flush_s;
  logic [1:0]  state_s;
  logic [7:0]  stall_cnt_s, flush_cnt_s;

  int checks;
  int errors;

  typedef struct {
    logic        hold;
    logic        bubble;
    logic        flush;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       jmp;
    logic       wr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    exp_t       exp;
  } vec_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .jmp_en(jmp_en),
    .hold(hold_m), .bubble(bubble_m), .flush(flush_m), .state(state_m),
    .stall_cnt(stall_cnt_m), .flush_cnt(flush_cnt_m)
  );

  pipe_hazard_ctrl #(.STALL_CYCLES(4), .FLUSH_CYCLES(1), .CNT_W(16)) dut5 (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .jmp_en(jmp_en),
    .hold(hold_5), .bubble(bubble_5), .flush(flush_5), .state(state_5),
    .stall_cnt(stall_cnt_5), .flush_cnt(flush_cnt_5)
  );

  pipe_hazard_ctrl #(.STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(8)) dut_sat (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .jmp_en(jmp_en),
    .hold(hold_s), .bubble(bubble_s), .flush(flush_s), .state(state_s),
    .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(int r, int j, int w, int rd, int rs1, int u1,
                                 int rs2, int u2, int h, int b, int f,
                                 int st, int sc, int fc);
    vec_t v;
    v.rst        = (r != 0);
    v.jmp        = (j != 0);
    v.wr         = (w != 0);
    v.rd         = 5'(rd);
    v.rs1        = 5'(rs1);
    v.u1         = (u1 != 0);
    v.rs2        = 5'(rs2);
    v.u2         = (u2 != 0);
    v.exp.hold   = (h != 0);
    v.exp.bubble = (b != 0);
    v.exp.flush  = (f != 0);
    v.exp.st     = 2'(st);
    v.exp.sc     = 16'(sc);
    v.exp.fc     = 16'(fc);
    return v;
  endfunction

  task automatic checkField(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setIdle();
    jmp_en      = 1'b0;
    ex_wr_en    = 1'b0;
    ex_rd       = 5'd0;
    id_rs1      = 5'd0;
    id_rs2      = 5'd0;
    id_rs1_used = 1'b0;
    id_rs2_used = 1'b0;
  endtask

  task automatic setHaz(input logic [4:0] r);
    ex_wr_en    = 1'b1;
    ex_rd       = r;
    id_rs1      = r;
    id_rs1_used = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    rst         = v.rst;
    jmp_en      = v.jmp;
    ex_wr_en    = v.wr;
    ex_rd       = v.rd;
    id_rs1      = v.rs1;
    id_rs1_used = v.u1;
    id_rs2      = v.rs2;
    id_rs2_used = v.u2;
    sb_q.push_back(v.exp);
  endtask

  task automatic checkOutput(input int idx);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1 at vector %0d", idx);
      return;
    end
    e = sb_q.pop_front();
    checkField($sformatf("v%0d.hold", idx),      32'(hold_m),      32'(e.hold));
    checkField($sformatf("v%0d.bubble", idx),    32'(bubble_m),    32'(e.bubble));
    checkField($sformatf("v%0d.flush", idx),     32'(flush_m),     32'(e.flush));
    checkField($sformatf("v%0d.state", idx),     32'(state_m),     32'(e.st));
    checkField($sformatf("v%0d.stall_cnt", idx), 32'(stall_cnt_m), 32'(e.sc));
    checkField($sformatf("v%0d.flush_cnt", idx), 32'(flush_cnt_m), 32'(e.fc));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    setIdle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    setIdle();

    // rst jmp wr rd rs1 u1 rs2 u2 | hold bubble flush state stall_cnt flush_cnt
    vecs.push_back(mkVec(1,1,1,5,5,1,0,0, 0,0,0,0,0,0));
    vecs.push_back(mkVec(0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mkVec(0,0,1,5,5,1,0,0, 1,1,0,0,0,0));
    vecs.push_back(mkVec(0,0,0,0,0,0,0,0, 1,1,0,1,1,0));
    vecs.push_back(mkVec(0,0,0,0,0,0,0,0, 0,0,0,0,1,0));
    vecs.push_back(mkVec(0,0,1,0,0,1,0,0, 0,0,0,0,1,0));
    vecs.push_back(mkVec(0,0,1,7,0,0,7,0, 0,0,0,0,1,0));
    vecs.push_back(mkVec(0,0,1,7,0,0,7,1, 1,1,0,0,1,0));
    vecs.push_back(mkVec(0,0,1,7,7,1,0,0, 1,1,0,1,2,0));
    vecs.push_back(mkVec(0,0,0,0,0,0,0,0, 0,0,0,0,2,0));
    vecs.push_back(mkVec(0,0,0,5,5,1,0,0, 0,0,0,0,2,0));
    vecs.push_back(mkVec(0,1,0,0,0,0,0,0, 0,0,1,0,2,0));
    vecs.push_back(mkVec(0,0,0,0,0,0,0,0, 0,0,1,2,2,1));
    vecs.push_back(mkVec(0,0,0,0,0,0,0,0, 0,0,0,0,2,1));
    vecs.push_back(mkVec(0,1,1,3,3,1,0,0, 0,0,1,0,2,1));
    vecs.push_back(mkVec(0,0,1,3,3,1,0,0, 0,0,1,2,2,2));
    vecs.push_back(mkVec(0,0,0,0,0,0,0,0, 0,0,0,0,2,2));
    vecs.push_back(mkVec(0,0,1,9,9,1,0,0, 1,1,0,0,2,2));
    vecs.push_back(mkVec(0,1,0,0,0,0,0,0, 0,0,1,1,3,2));
    vecs.push_back(mkVec(0,0,0,0,0,0,0,0, 0,0,1,2,3,3));
    vecs.push_back(mkVec(0,0,0,0,0,0,0,0, 0,0,0,0,3,3));
    vecs.push_back(mkVec(0,1,0,0,0,0,0,0, 0,0,1,0,3,3));
    vecs.push_back(mkVec(0,1,0,0,0,0,0,0, 0,0,1,2,3,4));
    vecs.push_back(mkVec(0,0,0,0,0,0,0,0, 0,0,1,2,3,5));
    vecs.push_back(mkVec(0,0,0,0,0,0,0,0, 0,0,0,0,3,5));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(i);
    end

    // Asynchronous reset between edges while flushing.
    @(negedge clk);
    jmp_en = 1'b1;
    #1;
    checkField("areset.pre_flush", 32'(flush_m), 32'd1);
    @(negedge clk);
    jmp_en = 1'b0;
    #1;
    checkField("areset.in_flush_state", 32'(state_m), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    checkField("areset.flush", 32'(flush_m), 32'd0);
    checkField("areset.state", 32'(state_m), 32'd0);
    checkField("areset.stall_cnt", 32'(stall_cnt_m), 32'd0);
    checkField("areset.flush_cnt", 32'(flush_cnt_m), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    setHaz(5'd12);
    #1;
    checkField("post_reset.hold", 32'(hold_m), 32'd1);
    @(negedge clk);
    setIdle();
    #1;
    checkField("post_reset.stall_cnt", 32'(stall_cnt_m), 32'd1);
    checkField("post_reset.state", 32'(state_m), 32'd1);

    // Long stall and single-cycle flush configuration.
    doReset();
    @(negedge clk);
    setHaz(5'd5);
    #1;
    checkField("p5.detect_hold", 32'(hold_5), 32'd1);
    checkField("p5.detect_state", 32'(state_5), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      setIdle();
      #1;
      checkField($sformatf("p5.stall%0d_hold", k), 32'(hold_5), 32'd1);
      checkField($sformatf("p5.stall%0d_bubble", k), 32'(bubble_5), 32'd1);
      checkField($sformatf("p5.stall%0d_state", k), 32'(state_5), 32'd1);
    end
    @(negedge clk);
    #1;
    checkField("p5.release_hold", 32'(hold_5), 32'd0);
    checkField("p5.release_state", 32'(state_5), 32'd0);
    @(negedge clk);
    jmp_en = 1'b1;
    #1;
    checkField("p5.jmp_flush", 32'(flush_5), 32'd1);
    @(negedge clk);
    jmp_en = 1'b0;
    #1;
    checkField("p5.after_jmp_flush", 32'(flush_5), 32'd0);
    checkField("p5.after_jmp_state", 32'(state_5), 32'd0);
    checkField("p5.stall_cnt", 32'(stall_cnt_5), 32'd1);
    checkField("p5.flush_cnt", 32'(flush_cnt_5), 32'd1);

    // Counter saturation on the narrow-counter instance.
    doReset();
    setHaz(5'd3);
    repeat (254) @(negedge clk);
    #1;
    checkField("sat.stall_254", 32'(stall_cnt_s), 32'hFE);
    @(negedge clk);
    #1;
    checkField("sat.stall_255", 32'(stall_cnt_s), 32'hFF);
    repeat (4) @(negedge clk);
    #1;
    checkField("sat.stall_259", 32'(stall_cnt_s), 32'hFF);
    setIdle();
    jmp_en = 1'b1;
    repeat (255) @(negedge clk);
    #1;
    checkField("sat.flush_255", 32'(flush_cnt_s), 32'hFF);
    repeat (4) @(negedge clk);
    #1;
    checkField("sat.flush_259", 32'(flush_cnt_s), 32'hFF);
    checkField("sat.stall_kept", 32'(stall_cnt_s), 32'hFF);
    setIdle();

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
